blinker_debounce: RTL and testbench
===================================

BLINKER_DEBOUNCE -- requirements
Module: blinker_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 1000: consecutive synchronized samples a new button level must hold before it is accepted; legal range 1 to 2^CNT_W-1.
REQ-002 Parameter CNT_W, default 12: stability counter width.
REQ-003 Port system1000  in  1: the single clock; all state updates on its rising edge.
REQ-004 Port system1000_rst  in  1: reset, synchronous and active-high.
REQ-005 Port btn_i  in  1: raw mechanical button level, asynchronous to system1000, may bounce.
REQ-006 Port output_0  out  1: debounced level; drives the 1-bit input of the blinker top entity.
REQ-007 Port press_o  out  1: one-cycle pulse on each accepted 0->1 transition.
REQ-008 Port release_o  out  1: one-cycle pulse on each accepted 1->0 transition.

Function
REQ-009 btn_i SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-010 Internal debounced register db and counter cnt (CNT_W bits); state machine STABLE (s2==db) / CHANGING (s2!=db).
REQ-011 STABLE: cnt held at 0; when s2 differs from db, move to CHANGING with cnt incremented to 1 on that edge, or accept immediately if STABLE_CYCLES==1.
REQ-012 CHANGING: cnt increments each cycle s2!=db; any cycle with s2==db clears cnt to 0 and returns to STABLE, with no output change.
REQ-013 Acceptance: on the edge where s2!=db and cnt==STABLE_CYCLES-1, db<=s2, cnt<=0, and the state returns to STABLE.
REQ-014 Latency: btn_i first sampled at edge N and held steady -> db changes at edge N+1+STABLE_CYCLES.
REQ-015 press_o/release_o SHALL be registered and high for exactly the one cycle following the acceptance edge of the matching direction; never both high.
REQ-016 cnt SHALL never exceed STABLE_CYCLES-1 and never wraps.
REQ-017 output_0 = db (registered, no combinational path from btn_i).
REQ-018 A bounce of any length shorter than STABLE_CYCLES samples SHALL produce no change on any output.

Reset
REQ-019 While system1000_rst=1 at an edge: s1, s2, db, cnt, toggle register, press_o, release_o, output_0 <= 0; state STABLE.
REQ-020 Reset mid-count SHALL discard the pending transition, with no pulse emitted.
REQ-021 Button held high across reset deassertion SHALL be treated as a new transition and accepted after the REQ-014 latency, with press_o pulsing.

Configuration
REQ-022 Macro BLINKER_DEBOUNCE_TOGGLE_EN: when defined, output_0 is a toggle register inverted on each cycle press_o is high (reset 0), giving latch-on/latch-off button behaviour.
REQ-023 When BLINKER_DEBOUNCE_TOGGLE_EN is undefined, output_0 = db and no toggle register exists.
REQ-024 press_o and release_o behaviour SHALL be identical in both builds.

Verification (STABLE_CYCLES=4)
REQ-025 Reset 2 cycles, then btn_i=1 held from edge N -> output_0 rises at edge N+5, press_o high one cycle, release_o stays 0.
REQ-026 btn_i pattern 1,1,1,0 repeated 10 times -> output_0, press_o, release_o remain 0 throughout.
REQ-027 From accepted high, btn_i=0 held from edge M -> output_0 falls at M+5, release_o single pulse.
REQ-028 btn_i=1 for 3 samples, then reset for 1 cycle, then btn_i=1 held -> no pulse before reset; press accepted 5 edges after first post-reset sample.
REQ-029 TOGGLE_EN build, two clean press/release cycles of 8 cycles each -> output_0 0->1->0, two press_o pulses, two release_o pulses.

Source files
------------

// File: rtl/blinker_debounce.sv
//------------------------------------------------------------------------------
// Module   : blinker_debounce
// Brief    : Two-flop synchronised, counter-based button debouncer with
//            registered press/release pulses. Defining BLINKER_DEBOUNCE_TOGGLE_EN
//            turns output_0 into a latch-on/latch-off toggle driven by presses.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module blinker_debounce #(
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W         = 12
) (
    input  logic system1000,
    input  logic system1000_rst,
    input  logic btn_i,
    output logic output_0,
    output logic press_o,
    output logic release_o
);

    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    state_t           r_state;
    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;

    logic w_diff;
    logic w_accept;

    assign w_diff   = r_s2 ^ r_db;
    // With STABLE_CYCLES==1, c_LAST is zero so acceptance happens from STABLE directly.
    assign w_accept = w_diff && (r_cnt == c_LAST);

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_db      <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_state   <= ST_STABLE;
        end else begin
            r_s1      <= btn_i;
            r_s2      <= r_s1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                ST_STABLE: begin
                    if (w_accept) begin
                        r_db      <= r_s2;
                        r_cnt     <= '0;
                        r_press   <= r_s2;
                        r_release <= ~r_s2;
                    end else if (w_diff) begin
                        r_cnt   <= r_cnt + c_ONE;
                        r_state <= ST_CHANGING;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ST_CHANGING: begin
                    if (!w_diff) begin
                        r_cnt   <= '0;
                        r_state <= ST_STABLE;
                    end else if (w_accept) begin
                        r_db      <= r_s2;
                        r_cnt     <= '0;
                        r_press   <= r_s2;
                        r_release <= ~r_s2;
                        r_state   <= ST_STABLE;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_STABLE;
                end
            endcase
        end
    end

    assign press_o   = r_press;
    assign release_o = r_release;

`ifdef BLINKER_DEBOUNCE_TOGGLE_EN
    logic r_toggle;

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_toggle <= 1'b0;
        end else if (r_press) begin
            r_toggle <= ~r_toggle;
        end
    end

    assign output_0 = r_toggle;
`else
    assign output_0 = r_db;
`endif

endmodule

`default_nettype wire

// File: tb/tb_blinker_debounce.sv
//------------------------------------------------------------------------------
// Module   : tb_blinker_debounce
// Brief    : Scoreboard bench for blinker_debounce (STABLE_CYCLES=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_blinker_debounce;

    localparam int SC = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic out0;
    logic press;
    logic rel;

    typedef struct packed {
        logic o;
        logic p;
        logic r;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 0;

    blinker_debounce #(
        .STABLE_CYCLES(SC),
        .CNT_W        (CW)
    ) dut (
        .system1000    (clk),
        .system1000_rst(rst),
        .btn_i         (btn),
        .output_0      (out0),
        .press_o       (press),
        .release_o     (rel)
    );

    always #5 clk = ~clk;

    // Reference: the accepted level flips once the last SC synchronised samples
    // seen since the previous acceptance/reset all disagree with it.
    initial begin : model
        logic m_s1, m_s2, m_db, m_press, m_rel, m_tog;
        logic hist[$];
        bit   all_diff;
        exp_t e;
        m_s1 = 0; m_s2 = 0; m_db = 0; m_press = 0; m_rel = 0; m_tog = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_s1 = 0; m_s2 = 0; m_db = 0; m_press = 0; m_rel = 0; m_tog = 0;
                hist.delete();
            end else begin
                m_tog = m_tog ^ m_press;
                hist.push_back(m_s2);
                m_s2 = m_s1;
                m_s1 = btn;
                if (hist.size() > SC) void'(hist.pop_front());
                m_press = 0;
                m_rel   = 0;
                if (hist.size() == SC) begin
                    all_diff = 1;
                    foreach (hist[i]) if (hist[i] == m_db) all_diff = 0;
                    if (all_diff) begin
                        m_db    = ~m_db;
                        m_press = m_db;
                        m_rel   = ~m_db;
                        hist.delete();
                    end
                end
            end
`ifdef BLINKER_DEBOUNCE_TOGGLE_EN
            e.o = m_tog;
`else
            e.o = m_db;
`endif
            e.p = m_press;
            e.r = m_rel;
            sb.push_back(e);
        end
    end

    initial begin : monitor
        exp_t exp_v;
        exp_t got;
        int   cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                got   = {out0, press, rel};
                n_tests++;
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: {output_0,press_o,release_o} got %b%b%b expected %b%b%b",
                             cyc, got.o, got.p, got.r, exp_v.o, exp_v.p, exp_v.r);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout: stimulus did not complete in time");
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    task automatic drive(input logic b, input logic r, input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            btn = b;
            rst = r;
        end
    endtask

    initial begin : stim
        int lvl;
        int len;
        drive(1'b0, 1'b1, 1);
        n_tests++;
        if ({out0, press, rel} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset state: {output_0,press_o,release_o} got %b%b%b expected 000",
                     out0, press, rel);
        end
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 10);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 3);
            drive(1'b0, 1'b0, 1);
        end
        drive(1'b0, 1'b0, 4);
        drive(1'b1, 1'b0, 3);
        drive(1'b1, 1'b1, 1);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 10);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 8);
            drive(1'b0, 1'b0, 8);
        end
        for (int i = 0; i < 80; i++) begin
            lvl = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            if ($urandom_range(0, 19) == 0) drive(lvl[0], 1'b1, 1);
            drive(lvl[0], 1'b0, len);
        end
        drive(1'b0, 1'b0, 12);
        @(negedge clk);
        @(negedge clk);
        #1;
        done = 1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
